bytebeat_gen: RTL

Parametrised bytebeat synthesis engine, successor to the fixed 4-coefficient top-level generator. A programmable prescaler advances a sample-time counter t. One of four selectable formulas combines t with four coefficients through a 2-stage pipeline. Samples leave on a valid/ready stream with overrun detection, and an on-chip PWM DAC drives a 1-bit audio pin.

---
 rtl/bytebeat_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bytebeat_gen.sv
// Bytebeat synthesis engine: prescaled sample clock, four selectable formulas in a
// two-register pipeline, valid/ready output with sticky overrun, and a PWM audio DAC.
module bytebeat_gen #(
  parameter int T_WIDTH    = 24,
  parameter int COEF_WIDTH = 4,
  parameter int PCM_WIDTH  = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [1:0]            mode,
  input  logic [COEF_WIDTH-1:0] coef_a,
  input  logic [COEF_WIDTH-1:0] coef_b,
  input  logic [COEF_WIDTH-1:0] coef_c,
  input  logic [COEF_WIDTH-1:0] coef_d,
  output logic [PCM_WIDTH-1:0]  pcm_data,
  output logic                  pcm_vld,
  input  logic                  pcm_rdy,
  output logic                  overrun,
  output logic [T_WIDTH-1:0]    t_out,
  output logic                  pwm_out
);

  // Logical right shift of the full-width t; shift counts past the width give zero.
  function automatic logic [T_WIDTH-1:0] shr_t(input logic [T_WIDTH-1:0]    v,
                                               input logic [COEF_WIDTH-1:0] sh);
    if (int'(sh) >= T_WIDTH) return '0;
    return v >> sh;
  endfunction

  function automatic logic [PCM_WIDTH-1:0] lo_pcm(input logic [T_WIDTH-1:0] v);
    return v[PCM_WIDTH-1:0];
  endfunction

  function automatic logic [PCM_WIDTH-1:0] coef_ext(input logic [COEF_WIDTH-1:0] c);
    return PCM_WIDTH'(c);
  endfunction

  // Only the low PCM bits of a product survive truncation, so narrow operands suffice.
  function automatic logic [PCM_WIDTH-1:0] mul_trunc(input logic [PCM_WIDTH-1:0] x,
                                                     input logic [PCM_WIDTH-1:0] y);
    logic [PCM_WIDTH-1:0] p;
    p = x * y;
    return p;
  endfunction

  function automatic logic [PCM_WIDTH-1:0] combine(input logic [1:0]           m,
                                                   input logic [PCM_WIDTH-1:0] ta,
                                                   input logic [PCM_WIDTH-1:0] tc,
                                                   input logic [PCM_WIDTH-1:0] sb,
                                                   input logic [PCM_WIDTH-1:0] sc,
                                                   input logic [PCM_WIDTH-1:0] sd,
                                                   input logic [PCM_WIDTH-1:0] tl,
                                                   input logic [PCM_WIDTH-1:0] m3);
    logic [PCM_WIDTH-1:0] r;
    case (m)
      2'd0:    r = ta & sb;
      2'd1:    r = ta | sb | sc;
      2'd2:    r = (ta & sb) ^ (tc & sd);
      default: r = mul_trunc(tl, m3);
    endcase
    return r;
  endfunction

  logic [DIV_WIDTH-1:0] presc_q;
  logic                 tick;
  logic [T_WIDTH-1:0]   t_q;

  assign tick  = ena && (presc_q >= div);
  assign t_out = t_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      t_q     <= '0;
    end else if (ena) begin
      presc_q <= tick ? '0 : presc_q + DIV_WIDTH'(1);
      if (tick) t_q <= t_q + T_WIDTH'(1);
    end
  end

  // Stage 0 -> 1: snapshot every term of t and the coefficients on the tick.
  logic [T_WIDTH-1:0]   sh_b_s0, sh_c_s0, sh_d_s0;
  logic [PCM_WIDTH-1:0] t_lo_s0;
  logic [PCM_WIDTH-1:0] ta_p1, tc_p1, sb_p1, sc_p1, sd_p1, tl_p1, m3_p1;
  logic [1:0]           mode_p1;
  logic                 vld_p1;

  assign sh_b_s0 = shr_t(t_q, coef_b);
  assign sh_c_s0 = shr_t(t_q, coef_c);
  assign sh_d_s0 = shr_t(t_q, coef_d);
  assign t_lo_s0 = lo_pcm(t_q);

  always_ff @(posedge clk) begin
    if (tick) begin
      mode_p1 <= mode;
      ta_p1   <= mul_trunc(t_lo_s0, coef_ext(coef_a));
      tc_p1   <= mul_trunc(t_lo_s0, coef_ext(coef_c));
      sb_p1   <= lo_pcm(sh_b_s0);
      sc_p1   <= lo_pcm(sh_c_s0);
      sd_p1   <= lo_pcm(sh_d_s0);
      tl_p1   <= t_lo_s0;
      m3_p1   <= lo_pcm((sh_b_s0 | sh_c_s0) & T_WIDTH'(coef_d));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= tick;
  end

  // Stage 1 -> 2: combine terms into the output register, which doubles as the stream buffer.
  logic [PCM_WIDTH-1:0] result_p1;
  logic [PCM_WIDTH-1:0] data_p2;
  logic                 vld_p2;
  logic                 overrun_q;
  logic                 load_p2;
  logic                 drop_p2;
  logic                 xfer_p2;

  assign result_p1 = combine(mode_p1, ta_p1, tc_p1, sb_p1, sc_p1, sd_p1, tl_p1, m3_p1);
  assign xfer_p2   = vld_p2 && pcm_rdy;
  assign load_p2   = vld_p1 && (!vld_p2 || pcm_rdy);
  assign drop_p2   = vld_p1 && vld_p2 && !pcm_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_p2   <= '0;
      vld_p2    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_p2) data_p2 <= result_p1;
      vld_p2 <= load_p2 || (vld_p2 && !pcm_rdy);
      if (drop_p2) overrun_q <= 1'b1;
    end
  end

  assign pcm_data = data_p2;
  assign pcm_vld  = vld_p2;
  assign overrun  = overrun_q;

  // PWM DAC: accepted samples wait in pwm_pend until the counter wraps, avoiding mid-period glitches.
  logic [PCM_WIDTH-1:0] pwm_cnt;
  logic [PCM_WIDTH-1:0] pwm_pend;
  logic [PCM_WIDTH-1:0] pwm_level;
  logic                 pwm_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      pwm_pend  <= '0;
      pwm_level <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PCM_WIDTH'(1);
      pwm_q   <= (pwm_cnt < pwm_level);
      if (&pwm_cnt) pwm_level <= pwm_pend;
      if (xfer_p2)  pwm_pend  <= data_p2;
    end
  end

  assign pwm_out = pwm_q;

endmodule
